muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide controller for the RV64 pipeline's execute stage. It accepts one M-extension operation from EX, runs a shift-add multiplier or restoring divider for XLEN cycles, and holds the pipeline with `stall` until the result is delivered. It sits beside the single-cycle ALU. The decoder routes an operation here when funct7 = 7'b0000001 and the opcode is OP.

## Interface
- `XLEN`, 64: operand and result width. Any even value ≥ 8 is legal.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid_in` input 1: an M-extension operation is present in EX. Held high, with stable operands, until `result_valid`.
- `funct3` input 3: selects the operation. 000 MUL, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` input XLEN: rs1 value (multiplicand or dividend).
- `op_b` input XLEN: rs2 value (multiplier or divisor).
- `flush` input 1: EX is being squashed (branch or exception). Aborts any operation.
- `stall` output 1: freeze IF/ID/EX. Combinational.
- `busy` output 1: state is BUSY.
- `result` output XLEN: result, valid when `result_valid` = 1.
- `result_valid` output 1: one-cycle pulse; EX/MEM captures `result`.
- `illegal` output 1: qualifies `result_valid` for funct3 001 or 010 (unsupported); `result` = 0 in that case.

## Operation
- States:
  - IDLE: waiting for an operation.
  - BUSY: iterating.
  - DONE: result delivered for one cycle.
- IDLE -> BUSY when `valid_in` = 1, `flush` = 0, and the operation is not a fast case. Operands are latched and the counter is loaded with XLEN.
- IDLE -> DONE directly (fast path) for these cases:
  - Divisor = 0:
    - DIV/DIVU: quotient = all ones.
    - REM/REMU: remainder = dividend.
  - DIV/REM with op_a = 2^(XLEN-1) and op_b = all ones:
    - DIV: quotient = op_a.
    - REM: remainder = 0.
  - Unsupported funct3: `result` = 0, `illegal` = 1.
- BUSY: one iteration per cycle. The counter decrements, and BUSY -> DONE on the cycle the counter reaches 1.
- MUL/MULHU: unsigned shift-add into a 2·XLEN product register.
  - MUL returns bits [XLEN-1:0].
  - MULHU returns bits [2·XLEN-1:XLEN].
  - Signed MUL needs no correction; low bits are identical.
- DIV/REM: operate on magnitudes, then correct signs in the DONE cycle.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Arithmetic is modulo 2^XLEN.
- DIVU/REMU: unsigned restoring division.
  - One-bit shift plus trial subtract per cycle.
  - The subtractor is XLEN+1 bits wide.
- DONE: `result_valid` = 1 and `stall` = 0, so the pipeline advances this cycle. DONE -> IDLE unconditionally. `valid_in` seen in DONE belongs to the departing instruction and is ignored.
- `stall` = `valid_in` & ~`flush` & (state != DONE).
- `flush` in any state: the next state is IDLE. No `result_valid` is produced for the aborted operation. Flush has priority over acceptance and over the DONE pulse, which is suppressed if both occur in the same cycle.
- Reset (async assert): state = IDLE; counter and operand registers = 0. Outputs:
  - `busy` = 0.
  - `result` = 0.
  - `result_valid` = 0.
  - `illegal` = 0.
  - `stall` follows `valid_in` (IDLE term).
- Reset mid-operation discards all work. The operation restarts only if `valid_in` is still high after release.

## Timing
- Cycle 0 is the first edge at which IDLE sees `valid_in` = 1.
- Iterative path:
  - BUSY cycles 1..XLEN.
  - DONE at cycle XLEN+1.
  - `stall` is high for XLEN+1 cycles.
  - Latency is XLEN+1 cycles; 65 cycles for XLEN = 64.
- Fast path: DONE at cycle 1; `stall` is high for cycle 0 only; latency 1.
- Back-to-back operations: the earliest next acceptance is the cycle after DONE (IDLE). There are no idle bubbles beyond that one DONE->IDLE transition.
- `result`, `result_valid`, `illegal` and `busy` are registered.
- `stall` is combinational from `valid_in`, `flush` and state, with no combinational path from `op_a` or `op_b`.

## Test plan
- **MUL, XLEN = 64.** Stimulus: op_a = 7, op_b = 6, funct3 000. Required: `busy` high cycles 1–64; `result_valid` at cycle 65 with `result` = 42; `stall` low at cycle 65.
- **MULHU.** Stimulus: op_a = op_b = 0xFFFF_FFFF_FFFF_FFFF. Required: `result` = 0xFFFF_FFFF_FFFF_FFFE.
- **Unsigned divide.**
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- **Signed divide.** Operands −7 and 2:
  - DIV -> −3 (0xFFFF_FFFF_FFFF_FFFD).
  - REM -> −1.
  - Both in 65 cycles.
- **Fast paths, each with `result_valid` at cycle 1:**
  - DIVU x/0 -> all ones.
  - REM 5/0 -> 5.
  - DIV 0x8000_0000_0000_0000 / −1 -> 0x8000_0000_0000_0000.
  - funct3 001 -> `illegal` = 1, `result` = 0.
- **Abort and recovery:**
  - `flush` at cycle 10 of a DIVU: state returns to IDLE at cycle 11 and no `result_valid` ever appears.
  - `rst_n` low at cycle 20 of a MUL: all outputs are 0 immediately.
  - With `valid_in` held, a new MUL completes 65 cycles after reset release.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV64 M-extension unit for the execute stage.
// One shift-add (MUL/MULHU) or restoring-divide (DIV/DIVU/REM/REMU) step per
// cycle over a shared hi:lo register pair; trivial divides and unsupported
// encodings complete in one cycle.
module muldiv_sequencer #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            illegal
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state, state_nx;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] hi, lo;       // mul: product hi:lo / div: remainder:dividend->quotient
    logic [XLEN-1:0] opnd;         // multiplicand or divisor magnitude
    logic            is_mul;       // latched: multiply vs divide
    logic            sel_hi;       // latched: MULHU or REM/REMU
    logic            neg_q, neg_r; // latched sign corrections for DIV/REM

    // Input decode and fast-path detection
    logic            is_div_in, signed_in, illegal_in, div_zero, div_ovf, fast;
    logic [XLEN-1:0] mag_a, mag_b, fast_res;

    // Decode the incoming operation and precompute one-cycle results
    always_comb begin
        is_div_in  = funct3[2];
        signed_in  = funct3[2] & ~funct3[0];
        illegal_in = (funct3 == 3'b001) || (funct3 == 3'b010);
        div_zero   = is_div_in && (op_b == '0);
        div_ovf    = signed_in && (op_a == MIN_NEG) && (op_b == '1);
        fast       = illegal_in | div_zero | div_ovf;
        mag_a      = (signed_in && op_a[XLEN-1]) ? -op_a : op_a;
        mag_b      = (signed_in && op_b[XLEN-1]) ? -op_b : op_b;
        fast_res   = '0;
        if (div_zero)
            fast_res = funct3[1] ? op_a : '1;
        else if (div_ovf)
            fast_res = funct3[1] ? '0 : op_a;
    end

    // One iteration step of either datapath
    logic [XLEN:0]   sum, rem_sh, diff;
    logic            ge;
    logic [XLEN-1:0] hi_nx, lo_nx, final_res;

    // Shift-add / restore-subtract step and final result selection
    always_comb begin
        // multiply: add multiplicand when the current multiplier bit is set,
        // then shift the whole product right by one
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        // divide: shift the next dividend bit into the partial remainder and
        // trial-subtract; the subtractor MSB is the borrow
        rem_sh = {hi, lo[XLEN-1]};
        diff   = rem_sh - {1'b0, opnd};
        ge     = ~diff[XLEN];
        if (is_mul) begin
            hi_nx = sum[XLEN:1];
            lo_nx = {sum[0], lo[XLEN-1:1]};
        end else begin
            hi_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            lo_nx = {lo[XLEN-2:0], ge};
        end
        if (is_mul)
            final_res = sel_hi ? hi_nx : lo_nx;
        else if (sel_hi)
            final_res = neg_r ? -hi_nx : hi_nx;
        else
            final_res = neg_q ? -lo_nx : lo_nx;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (valid_in) state_nx = fast ? S_DONE : S_BUSY;
            S_BUSY:  if (count == CW'(1)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    // Pipeline hold: only while an op is present and not yet delivered
    assign stall = valid_in & ~flush & (state != S_DONE);

    // State, registered outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            count        <= '0;
            hi           <= '0;
            lo           <= '0;
            opnd         <= '0;
            is_mul       <= 1'b0;
            sel_hi       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            state        <= state_nx;
            busy         <= (state_nx == S_BUSY);
            result_valid <= (state_nx == S_DONE);
            illegal      <= (state == S_IDLE) && (state_nx == S_DONE) && illegal_in;
            if (state_nx == S_DONE)
                result <= (state == S_IDLE) ? fast_res : final_res;

            if (state == S_IDLE && state_nx == S_BUSY) begin
                hi     <= '0;
                lo     <= is_div_in ? mag_a : op_b;
                opnd   <= is_div_in ? mag_b : op_a;
                count  <= CW'(XLEN);
                is_mul <= ~is_div_in;
                sel_hi <= funct3[1];
                neg_q  <= signed_in & (op_a[XLEN-1] ^ op_b[XLEN-1]);
                neg_r  <= signed_in & op_a[XLEN-1];
            end else if (state == S_BUSY) begin
                hi    <= hi_nx;
                lo    <= lo_nx;
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (XLEN = 64): directed cases,
// fast paths, flush/reset abort, back-to-back and randomized ops against an
// arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int XLEN = 64;
    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid_in = 1'b0;
    logic [2:0]      funct3 = 3'b000;
    logic [XLEN-1:0] op_a = '0;
    logic [XLEN-1:0] op_b = '0;
    logic            flush = 1'b0;
    logic            stall, busy, result_valid, illegal;
    logic [XLEN-1:0] result;

    int checks = 0;
    int failures = 0;

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall), .busy(busy),
        .result(result), .result_valid(result_valid), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reference model: RISC-V M semantics from plain arithmetic
    function automatic logic [63:0] model(input logic [2:0] f3, input logic [63:0] a,
                                          input logic [63:0] b, output logic ill);
        logic [127:0] p;
        longint sa, sb;
        logic ovf;
        ill = 1'b0;
        sa  = a;
        sb  = b;
        ovf = (a == MIN_NEG) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        p   = {64'd0, a} * {64'd0, b};
        case (f3)
            3'b000: return p[63:0];
            3'b011: return p[127:64];
            3'b100: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf ? a : 64'(sa / sb);
            3'b101: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 64'd0 : 64'(sa % sb);
            3'b111: return (b == 0) ? a : a % b;
            default: begin ill = 1'b1; return 64'd0; end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        return (f3 == 3'b001) || (f3 == 3'b010) || (f3[2] && b == 0) ||
               ((f3 == 3'b100 || f3 == 3'b110) && a == MIN_NEG && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    // Drive one op, hold valid until result_valid, measure latency (0 = timeout)
    task automatic run_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output logic ill, output int lat,
                          output int st_cnt, output int bz_cnt, output logic st_done);
        @(negedge clk);
        valid_in = 1'b1; funct3 = f3; op_a = a; op_b = b;
        #1;
        st_cnt = stall ? 1 : 0;
        bz_cnt = 0; lat = 0; res = '0; ill = 1'b0; st_done = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = n; res = result; ill = illegal; st_done = stall;
                break;
            end
            if (stall) st_cnt++;
            if (busy) bz_cnt++;
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || illegal !== 1'b0 || result !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b rv=%b ill=%b result=%h, required all 0", busy, result_valid, illegal, result);
        end
        valid_in = 1'b1; #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL reset_stall: stall=%b, required 1", stall); end
        valid_in = 1'b0; #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall_low: stall=%b, required 0", stall); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_mul();
        logic [63:0] r; logic il, sd; int lat, sc, bc;
        run_op(3'b000, 64'd7, 64'd6, r, il, lat, sc, bc, sd);
        checks++;
        if (r !== 64'd42 || lat != 65) begin failures++; $display("FAIL mul_7x6: result=%0d lat=%0d, required 42 lat 65", r, lat); end
        checks++;
        if (bc != 64 || sc != 65 || sd !== 1'b0 || il !== 1'b0) begin
            failures++; $display("FAIL mul_timing: busy_cycles=%0d stall_cycles=%0d stall_done=%b ill=%b, required 64 65 0 0", bc, sc, sd, il);
        end
    endtask

    task automatic test_mulhu();
        logic [63:0] r; logic il, sd; int lat, sc, bc;
        run_op(3'b011, '1, '1, r, il, lat, sc, bc, sd);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFE || lat != 65) begin failures++; $display("FAIL mulhu_max: result=%h lat=%0d, required fffffffffffffffe lat 65", r, lat); end
    endtask

    task automatic test_divide();
        logic [63:0] r; logic il, sd; int lat, sc, bc;
        run_op(3'b101, 64'd100, 64'd7, r, il, lat, sc, bc, sd);
        checks++;
        if (r !== 64'd14 || lat != 65) begin failures++; $display("FAIL divu_100_7: result=%0d lat=%0d, required 14 lat 65", r, lat); end
        run_op(3'b111, 64'd100, 64'd7, r, il, lat, sc, bc, sd);
        checks++;
        if (r !== 64'd2 || lat != 65) begin failures++; $display("FAIL remu_100_7: result=%0d lat=%0d, required 2 lat 65", r, lat); end
        run_op(3'b100, -64'sd7, 64'd2, r, il, lat, sc, bc, sd);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFD || lat != 65) begin failures++; $display("FAIL div_m7_2: result=%h lat=%0d, required fffffffffffffffd lat 65", r, lat); end
        run_op(3'b110, -64'sd7, 64'd2, r, il, lat, sc, bc, sd);
        checks++;
        if (r !== 64'hFFFF_FFFF_FFFF_FFFF || lat != 65) begin failures++; $display("FAIL rem_m7_2: result=%h lat=%0d, required ffffffffffffffff lat 65", r, lat); end
    endtask

    task automatic test_fast();
        logic [63:0] r; logic il, sd; int lat, sc, bc;
        run_op(3'b101, 64'd1234, 64'd0, r, il, lat, sc, bc, sd);
        checks++;
        if (r !== '1 || lat != 1 || sc != 1) begin failures++; $display("FAIL fast_divu_zero: result=%h lat=%0d stall=%0d, required all-ones lat 1 stall 1", r, lat, sc); end
        run_op(3'b110, 64'd5, 64'd0, r, il, lat, sc, bc, sd);
        checks++;
        if (r !== 64'd5 || lat != 1) begin failures++; $display("FAIL fast_rem_zero: result=%h lat=%0d, required 5 lat 1", r, lat); end
        run_op(3'b100, MIN_NEG, '1, r, il, lat, sc, bc, sd);
        checks++;
        if (r !== MIN_NEG || lat != 1) begin failures++; $display("FAIL fast_div_ovf: result=%h lat=%0d, required 8000000000000000 lat 1", r, lat); end
        run_op(3'b001, 64'd9, 64'd9, r, il, lat, sc, bc, sd);
        checks++;
        if (r !== '0 || il !== 1'b1 || lat != 1) begin failures++; $display("FAIL fast_illegal: result=%h ill=%b lat=%0d, required 0 1 lat 1", r, il, lat); end
        run_op(3'b000, 64'd3, 64'd3, r, il, lat, sc, bc, sd);
        checks++;
        if (il !== 1'b0 || r !== 64'd9) begin failures++; $display("FAIL illegal_clears: ill=%b result=%0d, required 0 9", il, r); end
    endtask

    task automatic test_flush();
        bit seen = 0;
        @(negedge clk);
        valid_in = 1'b1; funct3 = 3'b101; op_a = 64'd1000; op_b = 64'd3;
        @(posedge clk);
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_before: busy=%b, required 1", busy); end
        flush = 1'b1; #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL flush_stall: stall=%b, required 0", stall); end
        @(negedge clk);
        flush = 1'b0; valid_in = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin failures++; $display("FAIL flush_idle: busy=%b rv=%b, required 0 0", busy, result_valid); end
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (result_valid) seen = 1;
        end
        checks++;
        if (seen) begin failures++; $display("FAIL flush_no_result: result_valid seen=1, required 0"); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r; logic il, sd; int lat, sc, bc;
        run_op(3'b000, 64'd7, 64'd6, r, il, lat, sc, bc, sd);
        @(negedge clk);
        valid_in = 1'b1; funct3 = 3'b000; op_a = 64'd3; op_b = 64'd5;
        @(posedge clk);
        repeat (20) @(negedge clk);
        rst_n = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || result !== '0 || result_valid !== 1'b0 || illegal !== 1'b0) begin
            failures++; $display("FAIL reset_mid_outputs: busy=%b result=%h rv=%b ill=%b, required all 0", busy, result, result_valid, illegal);
        end
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL reset_mid_stall: stall=%b, required 1", stall); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (result_valid) begin lat = n; r = result; break; end
        end
        valid_in = 1'b0;
        checks++;
        if (lat != 65 || r !== 64'd15) begin failures++; $display("FAIL reset_restart: lat=%0d result=%0d, required 65 15", lat, r); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r; logic il, sd; int lat, sc, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(3'b000, 64'(i + 2), 64'd11, r, il, lat, sc, bc, sd);
            checks++;
            if (r !== 64'((i + 2) * 11) || lat != 65) begin failures++; $display("FAIL b2b_%0d: result=%0d lat=%0d, required %0d lat 65", i, r, lat, (i + 2) * 11); end
            @(negedge clk) ;
            checks++;
            if (result_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_pulse_%0d: rv=%b busy=%b, required 0 0", i, result_valid, busy); end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, r, exp; logic il, eil, sd; int lat, sc, bc, elat;
        logic [2:0] ops [6] = '{3'b000, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [2:0] f3;
        for (int i = 0; i < 30; i++) begin
            f3 = ops[$urandom_range(0, 5)];
            case ($urandom_range(0, 3))
                0: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
                1: begin a = 64'($urandom_range(0, 5000)); b = 64'($urandom_range(1, 50)); end
                2: begin a = -64'($urandom_range(1, 5000)); b = ($urandom_range(0, 1) != 0) ? -64'($urandom_range(1, 50)) : 64'($urandom_range(1, 50)); end
                default: begin a = {$urandom, $urandom}; b = ($urandom_range(0, 1) != 0) ? 64'd0 : 64'($urandom_range(1, 9)); end
            endcase
            exp  = model(f3, a, b, eil);
            elat = is_fast(f3, a, b) ? 1 : 65;
            run_op(f3, a, b, r, il, lat, sc, bc, sd);
            checks++;
            if (r !== exp || il !== eil || lat != elat) begin
                failures++;
                $display("FAIL rand_%0d f3=%b a=%h b=%h: result=%h ill=%b lat=%0d, required %h %b lat %0d", i, f3, a, b, r, il, lat, exp, eil, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulhu();
        test_divide();
        test_fast();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
